// File: rtl/mult_div_unit_if.sv
// Execute-stage bus between the control unit and the mult/div unit:
// operands, op select, MTHI/MTLO strobes, status flags and HI/LO.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic        wr_hi;
  logic        wr_lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, A_in, B_in, wr_hi, wr_lo,
    input  busy, done, div_zero, HI, LO
  );

  modport slave (
    input  start, op, A_in, B_in, wr_hi, wr_lo,
    output busy, done, div_zero, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers:
// 32 shift-add / restoring shift-subtract steps, then a sign-fix cycle.
module mult_div_unit (
  input  logic            clk_W,
  input  logic            rst,
  mult_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] m_q, m_d;
  logic        is_div_q, is_div_d;
  logic        neg_p_q, neg_p_d;
  logic        neg_r_q, neg_r_d;
  logic        bzero_q, bzero_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        divz_q, divz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        sa, sb;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift, div_trial;
  logic        div_ge;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign sa    = bus.op[0] & bus.A_in[31];
  assign sb    = bus.op[0] & bus.B_in[31];
  assign mag_a = sa ? -bus.A_in : bus.A_in;
  assign mag_b = sb ? -bus.B_in : bus.B_in;

  // acc = {partial product, unconsumed multiplier bits}, shifted right each step
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? m_q : 32'h0)};
  assign mul_next = {mul_sum, acc_q[31:1]};

  // acc = {remainder, dividend bits / quotient bits}, shifted left each step
  assign div_shift = acc_q[63:31];
  assign div_trial = div_shift - {1'b0, m_q};
  assign div_ge    = ~div_trial[32];
  assign div_next  = {(div_ge ? div_trial[31:0] : div_shift[31:0]), acc_q[30:0], div_ge};

  assign prod_fix = neg_p_q ? -acc_q : acc_q;
  assign quo_fix  = neg_p_q ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix  = neg_r_q ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    m_d      = m_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    bzero_d  = bzero_q;
    divz_d   = divz_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = CALC;
          cnt_d    = '0;
          divz_d   = 1'b0;
          is_div_d = bus.op[1];
          neg_p_d  = sa ^ sb;
          neg_r_d  = sa;
          bzero_d  = (bus.B_in == '0);
          m_d      = bus.op[1] ? mag_b : mag_a;
          acc_d    = {32'h0, (bus.op[1] ? mag_a : mag_b)};
        end else begin
          if (bus.wr_hi) hi_d = bus.A_in;
          if (bus.wr_lo) lo_d = bus.A_in;
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          // with a zero divisor the remainder path already yields |A| and
          // re-applies A's sign, so HI equals the raw dividend; only LO is forced
          lo_d   = bzero_q ? '1 : quo_fix;
          hi_d   = rem_fix;
          divz_d = bzero_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_W) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      bzero_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      bzero_q  <= bzero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      divz_q   <= divz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = divz_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed checks of mult_div_unit against an arithmetic
// reference model of HI/LO results, latency and MTHI/MTLO behaviour.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [31:0] exp_hi, exp_lo;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk_W (clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa64, sb64;
    int     sa, sb, q, r;
    logic [63:0] res;
    sa64 = longint'($signed(a));
    sb64 = longint'($signed(b));
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: res = {32'h0, a} * {32'h0, b};
      2'b01: res = sa64 * sb64;
      2'b10: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r, q};
        end
      end
    endcase
    return res;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int intf_k, input bit wr_with_start);
    bit ok;
    logic [63:0] r;
    r = model(o, a, b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.A_in  = a;
    bus.B_in  = b;
    bus.wr_hi = wr_with_start;
    bus.wr_lo = wr_with_start;
    ok = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.wr_hi = 1'b0;
      bus.wr_lo = 1'b0;
      bus.op    = 2'($urandom);
      bus.A_in  = $urandom;
      bus.B_in  = $urandom;
      if (k == intf_k) begin
        bus.start = 1'b1;
        bus.wr_hi = 1'b1;
      end
      if (!(bus.busy === 1'b1 && bus.done === 1'b0 && bus.div_zero === 1'b0 &&
            bus.HI === exp_hi && bus.LO === exp_lo)) ok = 1'b0;
    end
    check("busy_window", {63'h0, ok}, 64'h1);
    @(negedge clk);
    check("done",     {63'h0, bus.done}, 64'h1);
    check("busy_end", {63'h0, bus.busy}, 64'h0);
    check("HI", {32'h0, bus.HI}, {32'h0, r[63:32]});
    check("LO", {32'h0, bus.LO}, {32'h0, r[31:0]});
    check("div_zero", {63'h0, bus.div_zero}, {63'h0, (o[1] && b == 0)});
    exp_hi = r[63:32];
    exp_lo = r[31:0];
  endtask

  task automatic mt(input bit h, input bit l, input logic [31:0] v);
    bus.wr_hi = h;
    bus.wr_lo = l;
    bus.A_in  = v;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.A_in  = $urandom;
    if (h) exp_hi = v;
    if (l) exp_lo = v;
    check("mt_HI", {32'h0, bus.HI}, {32'h0, exp_hi});
    check("mt_LO", {32'h0, bus.LO}, {32'h0, exp_lo});
    check("mt_busy", {63'h0, bus.busy}, 64'h0);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.A_in  = '0;
    bus.B_in  = '0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'h0, bus.busy}, 64'h0);
    check("rst_done", {63'h0, bus.done}, 64'h0);
    check("rst_dz",   {63'h0, bus.div_zero}, 64'h0);
    check("rst_HI",   {32'h0, bus.HI}, 64'h0);
    check("rst_LO",   {32'h0, bus.LO}, 64'h0);
    rst = 1'b0;
    exp_hi = '0;
    exp_lo = '0;

    // Directed cases, issued back to back in the done cycle
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    check("multu_max", {bus.HI, bus.LO}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'b01, 32'hFFFF_FFFF, 32'h7FFF_FFFF, -1, 1'b0);
    check("mult_neg", {bus.HI, bus.LO}, 64'hFFFF_FFFF_8000_0001);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    check("div_neg7", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b10, 32'd100, 32'd7, -1, 1'b0);
    check("divu_100_7", {bus.HI, bus.LO}, {32'd2, 32'd14});
    run_op(2'b10, 32'h1234_5678, 32'h0, -1, 1'b0);
    check("divu_zero", {bus.HI, bus.LO}, 64'h1234_5678_FFFF_FFFF);
    run_op(2'b11, 32'h8000_0000, 32'h0, -1, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    check("div_ovf", {bus.HI, bus.LO}, 64'h0000_0000_8000_0000);

    // start + wr_hi at cycle 10 of a running op are ignored
    run_op(2'b00, 32'd3, 32'd5, 10, 1'b0);
    check("intf_result", {bus.HI, bus.LO}, {32'h0, 32'd15});
    @(negedge clk);
    check("done_pulse_one", {63'h0, bus.done}, 64'h0);
    mt(1'b1, 1'b0, 32'hDEAD_BEEF);
    mt(1'b0, 1'b1, 32'h0BAD_F00D);
    mt(1'b1, 1'b1, 32'h5555_AAAA);

    // MTHI/MTLO together with start: start wins (HI/LO held during CALC)
    run_op(2'b01, 32'hFFFF_FFF0, 32'd9, -1, 1'b1);

    // Reset in the middle of a DIVU
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.A_in  = 32'd1000;
    bus.B_in  = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {63'h0, bus.busy}, 64'h0);
    check("mid_rst_done", {63'h0, bus.done}, 64'h0);
    check("mid_rst_HILO", {bus.HI, bus.LO}, 64'h0);
    exp_hi = '0;
    exp_lo = '0;
    run_op(2'b10, 32'd1000, 32'd3, -1, 1'b0);

    // Randomized operations with biased corner operands
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'($urandom_range(0, 300));
        default: ;
      endcase
      run_op(o, a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit in the execute stage, directly downstream of the register file. It consumes the two register read operands (rs/rt) and computes MULT, MULTU, DIV and DIVU into dedicated HI/LO registers, which MFHI/MFLO read back for the write-back path. MTHI/MTLO write HI/LO directly. Each operation is multi-cycle, and the control unit stalls on `busy`.

## Interface
Parameters:
- none. The width is fixed at 32 bits and the iteration count is fixed at 32.

Ports:
- `clk_W`  in  1  — the only clock. All state updates on its rising edge.
- `rst`  in  1  — synchronous, active-high reset, sampled on the rising edge of `clk_W`.
- `start`  in  1  — request to begin the operation selected by `op`, using `A_in`/`B_in`.
- `op`  in  2  — operation select: 00 = MULTU, 01 = MULT, 10 = DIVU, 11 = DIV.
- `A_in`  in  32  — rs operand (multiplicand or dividend), and the data source for MTHI/MTLO.
- `B_in`  in  32  — rt operand (multiplier or divisor).
- `wr_hi`  in  1  — MTHI: write `A_in` into HI.
- `wr_lo`  in  1  — MTLO: write `A_in` into LO.
- `busy`  out  1  — high while an operation is in progress.
- `done`  out  1  — one-cycle pulse when HI/LO take a new result.
- `div_zero`  out  1  — set together with `done` for a divide whose divisor is 0. Held until the next accepted `start`.
- `HI`  out  32  — HI register.
- `LO`  out  32  — LO register.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - `start` = 1 at the edge: latch `op`, `A_in`, `B_in`; clear `div_zero`; clear the iteration counter; go to CALC.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at latch time.
  - Result signs are recorded: product sign = sign A xor sign B; quotient sign = sign A xor sign B; remainder sign = sign A.
- CALC:
  - Performs one iteration per edge, 32 edges total, using a 5-bit counter from 0 to 31.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract that produces the quotient and remainder magnitudes.
  - After the edge with counter = 31, go to FIX.
- FIX:
  - Apply sign correction by two's complement where the recorded sign is 1.
  - Multiply: HI/LO = 64-bit product.
  - Divide: LO = quotient, HI = remainder.
  - Pulse `done`, then return to IDLE.
- Divide rounding: the quotient truncates toward zero, and the remainder takes the sign of the dividend.
- Divisor = 0: the operation still runs the full latency. Result is LO = 32'hFFFF_FFFF, HI = dividend (`A_in` as latched, unmodified), `div_zero` = 1.
- DIV of 32'h8000_0000 by 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0. No flag is raised.
- `wr_hi` / `wr_lo`:
  - Honoured only in IDLE, and only when `start` = 0.
  - If `start` is also high, `start` wins and the writes are dropped.
  - While busy, the writes are ignored.
  - `wr_hi` and `wr_lo` may both be high in the same cycle; both registers are written.
- `start` while busy: ignored. The operation in flight is unaffected.
- Operands are held internally, so `A_in`/`B_in` may change freely after the accepting edge.
- HI/LO keep their old value during CALC and change only in FIX or on an MTHI/MTLO write.

## Timing
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `div_zero` = 0, HI = 0, LO = 0, counter = 0.
- Reset has priority over everything. Asserting `rst` mid-operation aborts it, discards the partial result, and zeroes HI/LO.
- Let E0 be the edge that accepts `start`:
  - `busy` = 1 from E0 through edge E33.
  - CALC runs on edges E1 to E32.
  - E33 (FIX) writes HI/LO.
  - After E33: `busy` = 0 and `done` = 1 for exactly one cycle.
- Latency: 33 cycles from acceptance to a valid result. Maximum issue rate is one operation per 34 cycles.
- A new `start` is accepted on edge E34 at the earliest, which is the cycle in which `done` is high.
- MTHI/MTLO: the value is visible on HI/LO the cycle after the write edge, with no busy phase.
- Outputs are registered. There is no combinational path from the inputs to any output.

## Test plan
- MULTU: A = 32'hFFFF_FFFF, B = 32'hFFFF_FFFF -> after 33 cycles `done` = 1, HI = 32'hFFFF_FFFE, LO = 32'h0000_0001.
- MULT: A = 32'hFFFF_FFFF, B = 32'h7FFF_FFFF -> HI = 32'hFFFF_FFFF, LO = 32'h8000_0001.
- DIV and DIVU:
  - DIV: A = 32'hFFFF_FFF9 (−7), B = 2 -> LO = 32'hFFFF_FFFD, HI = 32'hFFFF_FFFF.
  - DIVU: A = 100, B = 7 -> LO = 14, HI = 2.
- Divide edge cases:
  - DIVU: A = 32'h1234_5678, B = 0 -> LO = 32'hFFFF_FFFF, HI = 32'h1234_5678, `div_zero` = 1 with `done`.
  - DIV: A = 32'h8000_0000, B = 32'hFFFF_FFFF -> LO = 32'h8000_0000, HI = 0.
- Interference during an operation:
  - Start MULTU 3×5.
  - Pulse `start` with different operands and assert `wr_hi` at cycle 10 -> both are ignored; the result is HI = 0, LO = 15 at cycle 33.
  - Then MTHI with A = 32'hDEAD_BEEF -> HI = 32'hDEAD_BEEF on the next cycle.
- Reset mid-operation:
  - Assert `rst` at cycle 20 of a DIVU -> on the next cycle `busy` = 0, HI = LO = 0, and no `done` pulse ever appears.
  - A new `start` issued immediately after reset completes normally.
